// File: rtl/match_controller_pkg.sv
// Shared encodings for the fighter game: match FSM states, winner codes,
// player animation states and frame-rate helpers.
package game_pkg;

    localparam logic [2:0] MS_IDLE       = 3'd0;
    localparam logic [2:0] MS_COUNTDOWN  = 3'd1;
    localparam logic [2:0] MS_FIGHT      = 3'd2;
    localparam logic [2:0] MS_KO         = 3'd3;
    localparam logic [2:0] MS_ROUND_END  = 3'd4;
    localparam logic [2:0] MS_MATCH_OVER = 3'd5;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam logic [3:0] PS_IDLE      = 4'd0;
    localparam logic [3:0] PS_FWD       = 4'd1;
    localparam logic [3:0] PS_BACK      = 4'd2;
    localparam logic [3:0] PS_ATK_START = 4'd3;
    localparam logic [3:0] PS_ATK_END   = 4'd4;
    localparam logic [3:0] PS_ATK_PULL  = 4'd5;

    localparam int FRAMES_PER_SEC = 60;

    typedef struct packed {
        logic [9:0] x1;
        logic [9:0] x2;
        logic [9:0] y1;
        logic [9:0] y2;
    } box_t;

    // Whole seconds left, rounded up, so the display reads 3-2-1 rather than 2-1-0.
    function automatic logic [1:0] frames_to_sec(input logic [7:0] frames);
        logic [8:0] secs;
        secs = ({1'b0, frames} + 9'(FRAMES_PER_SEC - 1)) / 9'(FRAMES_PER_SEC);
        return secs[1:0];
    endfunction

endpackage

// File: rtl/match_controller_box_overlap.sv
// Combinational axis-aligned rectangle intersection with strict edges;
// degenerate (empty) boxes never intersect anything.
module box_overlap
    import game_pkg::*;
(
    input  logic [9:0] a_x1,
    input  logic [9:0] a_x2,
    input  logic [9:0] a_y1,
    input  logic [9:0] a_y2,
    input  logic [9:0] b_x1,
    input  logic [9:0] b_x2,
    input  logic [9:0] b_y1,
    input  logic [9:0] b_y2,
    output logic       hit
);

    box_t a;
    box_t b;
    logic a_empty;
    logic b_empty;

    assign a = '{x1: a_x1, x2: a_x2, y1: a_y1, y2: a_y2};
    assign b = '{x1: b_x1, x2: b_x2, y1: b_y1, y2: b_y2};

    assign a_empty = (a.x1 >= a.x2) || (a.y1 >= a.y2);
    assign b_empty = (b.x1 >= b.x2) || (b.y1 >= b.y2);

    assign hit = !a_empty && !b_empty &&
                 (a.x1 < b.x2) && (b.x1 < a.x2) &&
                 (a.y1 < b.y2) && (b.y1 < a.y2);

endmodule

// File: rtl/match_controller.sv
// Combat referee and round sequencer: applies one hit per attack, tracks
// health and round wins, and runs countdown/fight/KO/round-end per frame.
module match_controller
    import game_pkg::*;
#(
    parameter int         MAX_HEALTH          = 100,
    parameter int         DAMAGE              = 10,
    parameter logic [3:0] ATTACK_ACTIVE_STATE = 4'd4,
    parameter int         COUNTDOWN_FRAMES    = 180,
    parameter int         KO_FRAMES           = 120,
    parameter int         ROUNDS_TO_WIN       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic [9:0] p1_hit_x1,
    input  logic [9:0] p1_hit_x2,
    input  logic [9:0] p1_hit_y1,
    input  logic [9:0] p1_hit_y2,
    input  logic [9:0] p2_hit_x1,
    input  logic [9:0] p2_hit_x2,
    input  logic [9:0] p2_hit_y1,
    input  logic [9:0] p2_hit_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,
    output logic [7:0] health1,
    output logic [7:0] health2,
    output logic [1:0] wins1,
    output logic [1:0] wins2,
    output logic [2:0] match_state,
    output logic [1:0] winner,
    output logic       controls_enable,
    output logic       hit1_pulse,
    output logic       hit2_pulse,
    output logic [1:0] countdown_sec
);

    localparam logic [7:0] HEALTH_INIT = 8'(MAX_HEALTH);
    localparam logic [8:0] DAMAGE_9    = 9'(DAMAGE);
    localparam logic [7:0] CD_INIT     = 8'(COUNTDOWN_FRAMES);
    localparam logic [7:0] KO_INIT     = 8'(KO_FRAMES);
    localparam logic [1:0] WINS_NEEDED = 2'(ROUNDS_TO_WIN);

    function automatic logic [7:0] sat_sub(input logic [7:0] h);
        logic [8:0] diff;
        diff = {1'b0, h} - DAMAGE_9;
        return diff[8] ? 8'd0 : diff[7:0];
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] w);
        return (w == 2'd3) ? w : w + 2'd1;
    endfunction

    logic       ov1;
    logic       ov2;
    logic       atk1;
    logic       atk2;
    logic       land1;
    logic       land2;
    logic       new_round;

    logic [2:0] state_q,   state_d;
    logic [7:0] counter_q, counter_d;
    logic [7:0] health1_q, health1_d;
    logic [7:0] health2_q, health2_d;
    logic [1:0] wins1_q,   wins1_d;
    logic [1:0] wins2_q,   wins2_d;
    logic [1:0] winner_q,  winner_d;
    logic       latch1_q,  latch1_d;
    logic       latch2_q,  latch2_d;
    logic       ctrl_en_q, ctrl_en_d;
    logic       hit1_pulse_q, hit1_pulse_d;
    logic       hit2_pulse_q, hit2_pulse_d;

    box_overlap u_p1_strike (
        .a_x1(p1_hit_x1),  .a_x2(p1_hit_x2),  .a_y1(p1_hit_y1),  .a_y2(p1_hit_y2),
        .b_x1(p2_hurt_x1), .b_x2(p2_hurt_x2), .b_y1(p2_hurt_y1), .b_y2(p2_hurt_y2),
        .hit (ov1)
    );

    box_overlap u_p2_strike (
        .a_x1(p2_hit_x1),  .a_x2(p2_hit_x2),  .a_y1(p2_hit_y1),  .a_y2(p2_hit_y2),
        .b_x1(p1_hurt_x1), .b_x2(p1_hurt_x2), .b_y1(p1_hurt_y1), .b_y2(p1_hurt_y2),
        .hit (ov2)
    );

    assign atk1  = (p1_state == ATTACK_ACTIVE_STATE);
    assign atk2  = (p2_state == ATTACK_ACTIVE_STATE);
    assign land1 = atk1 && !latch1_q && ov1;
    assign land2 = atk2 && !latch2_q && ov2;

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        health1_d    = health1_q;
        health2_d    = health2_q;
        wins1_d      = wins1_q;
        wins2_d      = wins2_q;
        winner_d     = winner_q;
        latch1_d     = latch1_q;
        latch2_d     = latch2_q;
        hit1_pulse_d = 1'b0;
        hit2_pulse_d = 1'b0;
        new_round    = 1'b0;

        if (frame_tick) begin
            // Leaving the active frame re-arms the attacker for its next swing.
            if (!atk1) latch1_d = 1'b0;
            if (!atk2) latch2_d = 1'b0;

            case (state_q)
                MS_IDLE, MS_MATCH_OVER: begin
                    if (start) begin
                        new_round = 1'b1;
                        wins1_d   = 2'd0;
                        wins2_d   = 2'd0;
                    end
                end
                MS_COUNTDOWN: begin
                    counter_d = counter_q - 8'd1;
                    if (counter_q <= 8'd1) begin
                        counter_d = 8'd0;
                        state_d   = MS_FIGHT;
                    end
                end
                MS_FIGHT: begin
                    if (land1) begin
                        health2_d    = sat_sub(health2_q);
                        hit1_pulse_d = 1'b1;
                        latch1_d     = 1'b1;
                    end
                    if (land2) begin
                        health1_d    = sat_sub(health1_q);
                        hit2_pulse_d = 1'b1;
                        latch2_d     = 1'b1;
                    end
                    if (health1_d == 8'd0 || health2_d == 8'd0) begin
                        state_d   = MS_KO;
                        counter_d = KO_INIT;
                        if (health1_d == 8'd0 && health2_d == 8'd0) begin
                            winner_d = WIN_DRAW;
                        end else if (health2_d == 8'd0) begin
                            winner_d = WIN_P1;
                            wins1_d  = sat_inc(wins1_q);
                        end else begin
                            winner_d = WIN_P2;
                            wins2_d  = sat_inc(wins2_q);
                        end
                    end
                end
                MS_KO: begin
                    counter_d = counter_q - 8'd1;
                    if (counter_q <= 8'd1) begin
                        counter_d = 8'd0;
                        state_d   = MS_ROUND_END;
                    end
                end
                MS_ROUND_END: begin
                    if (wins1_q >= WINS_NEEDED || wins2_q >= WINS_NEEDED) begin
                        state_d = MS_MATCH_OVER;
                    end else begin
                        new_round = 1'b1;
                    end
                end
                default: state_d = MS_IDLE;
            endcase

            if (new_round) begin
                state_d   = MS_COUNTDOWN;
                counter_d = CD_INIT;
                health1_d = HEALTH_INIT;
                health2_d = HEALTH_INIT;
                winner_d  = WIN_NONE;
                latch1_d  = 1'b0;
                latch2_d  = 1'b0;
            end
        end

        ctrl_en_d = (state_d == MS_FIGHT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MS_IDLE;
            counter_q    <= 8'd0;
            health1_q    <= HEALTH_INIT;
            health2_q    <= HEALTH_INIT;
            wins1_q      <= 2'd0;
            wins2_q      <= 2'd0;
            winner_q     <= WIN_NONE;
            latch1_q     <= 1'b0;
            latch2_q     <= 1'b0;
            ctrl_en_q    <= 1'b0;
            hit1_pulse_q <= 1'b0;
            hit2_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            health1_q    <= health1_d;
            health2_q    <= health2_d;
            wins1_q      <= wins1_d;
            wins2_q      <= wins2_d;
            winner_q     <= winner_d;
            latch1_q     <= latch1_d;
            latch2_q     <= latch2_d;
            ctrl_en_q    <= ctrl_en_d;
            hit1_pulse_q <= hit1_pulse_d;
            hit2_pulse_q <= hit2_pulse_d;
        end
    end

    assign health1         = health1_q;
    assign health2         = health2_q;
    assign wins1           = wins1_q;
    assign wins2           = wins2_q;
    assign match_state     = state_q;
    assign winner          = winner_q;
    assign controls_enable = ctrl_en_q;
    assign hit1_pulse      = hit1_pulse_q;
    assign hit2_pulse      = hit2_pulse_q;
    assign countdown_sec   = (state_q == MS_COUNTDOWN) ? frames_to_sec(counter_q) : 2'd0;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed scenarios plus randomized play, all
// compared every cycle against a frame-level reference model.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       start;
    logic [3:0] p1_state, p2_state;
    logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
    logic [7:0] health1, health2;
    logic [1:0] wins1, wins2;
    logic [2:0] match_state;
    logic [1:0] winner;
    logic       controls_enable;
    logic       hit1_pulse, hit2_pulse;
    logic [1:0] countdown_sec;

    always #5 clk = ~clk;

    match_controller dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .health1(health1), .health2(health2), .wins1(wins1), .wins2(wins2),
        .match_state(match_state), .winner(winner), .controls_enable(controls_enable),
        .hit1_pulse(hit1_pulse), .hit2_pulse(hit2_pulse), .countdown_sec(countdown_sec)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model: match phase, remaining frames, health, wins, winner.
    int m_state, m_cnt, m_h1, m_h2, m_w1, m_w2, m_win, m_p1, m_p2;
    bit m_l1, m_l2;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit ovl(input int ax1, input int ax2, input int ay1, input int ay2,
                               input int bx1, input int bx2, input int by1, input int by2);
        if (ax1 >= ax2 || ay1 >= ay2 || bx1 >= bx2 || by1 >= by2) return 1'b0;
        return (ax1 < bx2) && (bx1 < ax2) && (ay1 < by2) && (by1 < ay2);
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_h1 = 100; m_h2 = 100;
        m_w1 = 0; m_w2 = 0; m_win = 0; m_p1 = 0; m_p2 = 0; m_l1 = 0; m_l2 = 0;
    endtask

    task automatic model_new_round();
        m_state = 1; m_cnt = 180; m_h1 = 100; m_h2 = 100; m_win = 0; m_l1 = 0; m_l2 = 0;
    endtask

    task automatic model_step();
        bit a1, a2, s1, s2;
        m_p1 = 0; m_p2 = 0;
        if (frame_tick !== 1'b1) return;
        a1 = (p1_state == 4);
        a2 = (p2_state == 4);
        s1 = a1 && !m_l1 && ovl(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                                p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
        s2 = a2 && !m_l2 && ovl(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                                p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);
        if (!a1) m_l1 = 0;
        if (!a2) m_l2 = 0;
        case (m_state)
            0, 5: if (start) begin model_new_round(); m_w1 = 0; m_w2 = 0; end
            1: begin m_cnt--; if (m_cnt == 0) m_state = 2; end
            2: begin
                if (s1) begin m_h2 = (m_h2 > 10) ? m_h2 - 10 : 0; m_p1 = 1; m_l1 = 1; end
                if (s2) begin m_h1 = (m_h1 > 10) ? m_h1 - 10 : 0; m_p2 = 1; m_l2 = 1; end
                if (m_h1 == 0 || m_h2 == 0) begin
                    m_state = 3; m_cnt = 120;
                    if (m_h1 == 0 && m_h2 == 0) m_win = 3;
                    else if (m_h2 == 0) begin m_win = 1; if (m_w1 < 3) m_w1++; end
                    else begin m_win = 2; if (m_w2 < 3) m_w2++; end
                end
            end
            3: begin m_cnt--; if (m_cnt == 0) m_state = 4; end
            4: if (m_w1 >= 2 || m_w2 >= 2) m_state = 5; else model_new_round();
            default: m_state = 0;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",   match_state, m_state);
            chk("health1", health1, m_h1);
            chk("health2", health2, m_h2);
            chk("wins1",   wins1, m_w1);
            chk("wins2",   wins2, m_w2);
            chk("winner",  winner, m_win);
            chk("ctrl_en", controls_enable, (m_state == 2) ? 1 : 0);
            chk("hit1p",   hit1_pulse, m_p1);
            chk("hit2p",   hit2_pulse, m_p2);
            chk("cd_sec",  countdown_sec, (m_state == 1) ? (m_cnt + 59) / 60 : 0);
        end
    end

    task automatic clk_cycle(input bit tick);
        frame_tick = tick;
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            clk_cycle(1'b1);
            clk_cycle(1'b0);
        end
    endtask

    task automatic attack(input bit a1, input bit a2);
        p1_state = 4'd5; p2_state = 4'd5;
        ticks(1);
        p1_state = a1 ? 4'd4 : 4'd0;
        p2_state = a2 ? 4'd4 : 4'd0;
        ticks(1);
        p1_state = 4'd0; p2_state = 4'd0;
    endtask

    task automatic set_fight_boxes();
        p1_hit_x1 = 200; p1_hit_x2 = 300; p1_hit_y1 = 100; p1_hit_y2 = 150;
        p2_hurt_x1 = 290; p2_hurt_x2 = 400; p2_hurt_y1 = 50; p2_hurt_y2 = 250;
        p2_hit_x1 = 240; p2_hit_x2 = 320; p2_hit_y1 = 100; p2_hit_y2 = 150;
        p1_hurt_x1 = 150; p1_hurt_x2 = 250; p1_hurt_y1 = 50; p1_hurt_y2 = 250;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_state"}, match_state, 0);
        chk({tag, "_h1"}, health1, 100);
        chk({tag, "_h2"}, health2, 100);
        chk({tag, "_wins"}, {wins1, wins2}, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_ctrl"}, controls_enable, 0);
        chk({tag, "_pulses"}, {hit1_pulse, hit2_pulse}, 0);
        chk({tag, "_cd"}, countdown_sec, 0);
    endtask

    initial begin
        int pc;
        rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
        p1_state = 4'd0; p2_state = 4'd0;
        set_fight_boxes();
        model_reset();
        clk_cycle(1'b0); clk_cycle(1'b1);
        rst = 1'b0;
        clk_cycle(1'b0);
        chk_en = 1'b1;
        reset_checks("reset");

        // 1: start, countdown of 180 frames, then FIGHT
        start = 1'b1; ticks(1); start = 1'b0;
        chk("t1_state", match_state, 1);
        chk("t1_cd", countdown_sec, 3);
        ticks(179);
        chk("t1_still_cd", match_state, 1);
        chk("t1_cd_last", countdown_sec, 1);
        ticks(1);
        chk("t1_fight", match_state, 2);
        chk("t1_ctrl", controls_enable, 1);

        // 2: held attack hits once; re-attack hits again
        p2_hit_x1 = 0; p2_hit_x2 = 0; p2_hit_y1 = 0; p2_hit_y2 = 0;
        p1_state = 4'd4; pc = 0;
        for (int k = 0; k < 5; k++) begin
            clk_cycle(1'b1); pc += int'(hit1_pulse);
            clk_cycle(1'b0); pc += int'(hit1_pulse);
        end
        chk("t2_pulses", pc, 1);
        chk("t2_h2", health2, 90);
        attack(1'b1, 1'b0);
        chk("t2_h2_again", health2, 80);

        // 3: edge touch and empty boxes never hit
        p1_hit_x2 = 290;
        attack(1'b1, 1'b0);
        chk("t3_edge", health2, 80);
        p1_hit_x1 = 0; p1_hit_x2 = 0;
        attack(1'b1, 1'b0);
        chk("t3_empty0", health2, 80);
        p1_hit_x1 = 350; p1_hit_x2 = 350;
        attack(1'b1, 1'b0);
        chk("t3_empty_inside", health2, 80);

        // 4: trade at 10/10 gives a draw KO
        set_fight_boxes();
        for (int k = 0; k < 9; k++) attack(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) attack(1'b1, 1'b0);
        chk("t4_h1_10", health1, 10);
        chk("t4_h2_10", health2, 10);
        attack(1'b1, 1'b1);
        chk("t4_ko", match_state, 3);
        chk("t4_h", {health1, health2}, 0);
        chk("t4_draw", winner, 3);
        chk("t4_wins", {wins1, wins2}, 0);
        ticks(120);
        chk("t4_round_end", match_state, 4);
        ticks(1);
        chk("t4_countdown", match_state, 1);
        chk("t4_h_reset", {health1, health2}, {8'd100, 8'd100});

        // 5: P1 takes two rounds
        for (int r = 0; r < 2; r++) begin
            ticks(180);
            for (int k = 0; k < 10; k++) attack(1'b1, 1'b0);
            chk("t5_ko", match_state, 3);
            chk("t5_winner", winner, 1);
            chk("t5_wins1", wins1, r + 1);
            ticks(121);
        end
        chk("t5_over", match_state, 5);
        chk("t5_winner_held", winner, 1);
        chk("t5_wins1_final", wins1, 2);
        start = 1'b1; ticks(1); start = 1'b0;
        chk("t5_restart", match_state, 1);
        chk("t5_wins_clr", {wins1, wins2}, 0);

        // 6: asynchronous reset mid-FIGHT without a tick
        ticks(180);
        attack(1'b0, 1'b1);
        chk("t6_pre_h1", health1, 90);
        rst = 1'b1;
        model_reset();
        #2;
        reset_checks("t6");
        clk_cycle(1'b0);
        rst = 1'b0;
        clk_cycle(1'b0);

        // Randomized play
        for (int i = 0; i < 6000; i++) begin
            start    = ($urandom_range(0, 15) == 0);
            p1_state = 4'($urandom_range(0, 5));
            p2_state = 4'($urandom_range(0, 5));
            p1_hit_x1 = 10'($urandom_range(0, 63)); p1_hit_x2 = 10'($urandom_range(0, 63));
            p1_hit_y1 = 10'($urandom_range(0, 63)); p1_hit_y2 = 10'($urandom_range(0, 63));
            p2_hit_x1 = 10'($urandom_range(0, 63)); p2_hit_x2 = 10'($urandom_range(0, 63));
            p2_hit_y1 = 10'($urandom_range(0, 63)); p2_hit_y2 = 10'($urandom_range(0, 63));
            p1_hurt_x1 = 10'($urandom_range(0, 31)); p1_hurt_x2 = 10'($urandom_range(32, 63));
            p1_hurt_y1 = 10'($urandom_range(0, 31)); p1_hurt_y2 = 10'($urandom_range(32, 63));
            p2_hurt_x1 = 10'($urandom_range(0, 31)); p2_hurt_x2 = 10'($urandom_range(32, 63));
            p2_hurt_y1 = 10'($urandom_range(0, 31)); p2_hurt_y2 = 10'($urandom_range(32, 63));
            clk_cycle(1'($urandom_range(0, 1)));
            if (i == 3000) begin
                rst = 1'b1;
                model_reset();
                clk_cycle(1'b1);
                rst = 1'b0;
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Per-frame combat referee and round sequencer for the two-player fighter. It tests each player's basic hit-hurtbox against the opponent's main hurtbox and applies damage once per attack. It tracks health, runs the countdown/fight/KO/round-end state machine, and gates player controls. It sits between the two player instances and color_decider/HEX drivers, clocked by the system clock with a one-cycle-per-frame strobe.

Parameters:
MAX_HEALTH, 100, starting health per round (fits 8 bits)
DAMAGE, 10, health removed per landed hit
ATTACK_ACTIVE_STATE, 4'd4, player current_state code in which the hit-hurtbox is live
COUNTDOWN_FRAMES, 180, frames in COUNTDOWN before FIGHT
KO_FRAMES, 120, frames held in KO before ROUND_END
ROUNDS_TO_WIN, 2, round wins needed to take the match

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  level; begins a match from IDLE or MATCH_OVER
p1_state, p2_state  in  4 each  player current_state
p1_hit_x1/x2/y1/y2, p2_hit_x1/x2/y1/y2  in  10 each  basic hit-hurtbox corners
p1_hurt_x1/x2/y1/y2, p2_hurt_x1/x2/y1/y2  in  10 each  main hurtbox corners
health1, health2  out  8 each  current health
wins1, wins2  out  2 each  rounds won this match
match_state  out  3  IDLE=0, COUNTDOWN=1, FIGHT=2, KO=3, ROUND_END=4, MATCH_OVER=5
winner  out  2  0 none, 1 P1, 2 P2, 3 draw (valid in KO/MATCH_OVER)
controls_enable  out  1  high only in FIGHT; ANDed into player inputs at top level
hit1_pulse, hit2_pulse  out  1 each  one-cycle pulse when P1 lands on P2 / P2 lands on P1
countdown_sec  out  2  ceil(remaining countdown frames / 60), 0 outside COUNTDOWN

Behaviour:
- Reset: state IDLE, health1=health2=MAX_HEALTH, wins=0, winner=0, controls_enable=0, pulses=0, frame counter=0, hit latches clear.
- All state, counter and hit evaluation advances only on cycles with frame_tick=1. Outputs are registered and change the cycle after the tick.
- Overlap(A,B) = A.x1<B.x2 && B.x1<A.x2 && A.y1<B.y2 && B.y1<A.y2, evaluated combinationally. Strict compares: edge-touching boxes do not hit. A box with x1>=x2 or y1>=y2 is empty and never overlaps.
- Hit rule for P1 (P2 symmetric): in FIGHT, on a tick, if p1_state==ATTACK_ACTIVE_STATE, latch1 clear, and Overlap(p1_hit, p2_hurt):
  - health2 <= sat0(health2-DAMAGE)
  - hit1_pulse=1
  - latch1 set
- latch1 clears on the first tick with p1_state!=ATTACK_ACTIVE_STATE, so each attack hits at most once.
- Simultaneous hits on the same tick both apply (trade).
- FSM transitions:
  - IDLE: start on a tick -> COUNTDOWN; health reset, wins cleared, counter=COUNTDOWN_FRAMES.
  - COUNTDOWN: counter decrements per tick; at 0 -> FIGHT.
  - FIGHT: after hit updates, any health==0 -> KO, counter=KO_FRAMES.
    - winner=1 if only health2==0; 2 if only health1==0; 3 if both.
    - Winner increments its win count (saturate at 3). A draw awards no round.
  - KO: counter decrements; at 0 -> ROUND_END.
  - ROUND_END (one tick): wins1 or wins2 >= ROUNDS_TO_WIN -> MATCH_OVER, winner held. Otherwise health reset, winner=0, -> COUNTDOWN.
  - MATCH_OVER: start on a tick -> same actions as from IDLE.
- No hits are evaluated outside FIGHT. Latches clear on entry to COUNTDOWN.
- rst asserted mid-match returns everything to the reset values immediately, regardless of frame_tick.
- Subtraction: 9-bit intermediate, clamped to 0. Never wraps.

Decomposition:
- Shared package (game_pkg) holds:
  - match_state encodings
  - winner codes
  - player state code constants (IDLE=0, FWD=1, BACK=2, ATK_START=3, ATK_END=4, ATK_PULL=5)
  - the 60 frames/second constant
- One sub-module: box_overlap (two 4×10-bit boxes in, 1-bit hit out, purely combinational), instantiated twice.

Test Plan:
1. rst pulse, then start + tick -> match_state=1, countdown_sec=3. After 180 ticks -> state=2, controls_enable=1.
2. P1 hit box (200,300,100,150) vs P2 hurt (290,400,50,250), p1_state=4 held 5 ticks -> health2 100->90 once, single hit1_pulse. State 5 then 4 again -> 80.
3. Hit box x2=290 against hurt x1=290 (edge touch) -> no damage. Box with x1=x2=0 -> no damage.
4. Both players state 4 overlapping on the same tick with health1=health2=10 -> both 0, state KO, winner=3, wins unchanged. After 120 ticks, ROUND_END -> COUNTDOWN, health 100/100.
5. P1 KOs P2 twice (health2 reaching 0 in each round) -> after second KO+ROUND_END, state=5, winner=1, wins1=2. Start -> COUNTDOWN, wins cleared.
6. Assert rst mid-FIGHT with no frame_tick -> next cycle all outputs at reset values, state IDLE.
